// File: rtl/simd_mul_unit_pkg.sv
// Shared types for the packed-SIMD multiply unit: op codes, issue struct,
// core config and the per-op lane count.
package simd_mul_unit_pkg;
  typedef struct packed {
    int unsigned XLEN;
  } cva6_cfg_t;

  localparam cva6_cfg_t cva6_cfg_empty = '{XLEN: 32};
  localparam int unsigned TRANS_ID_BITS = 3;

  typedef enum logic [1:0] {FU_NONE, ALU, SIMD_ALU, SIMD_MUL} fu_t;

  typedef enum logic [7:0] {
    ADD    = 8'h00,
    SMAQA  = 8'h70,
    UMAQA  = 8'h71,
    KHM8   = 8'h72,
    KHM16  = 8'h73,
    SMBB16 = 8'h74
  } fu_op;

  typedef struct packed {
    fu_op                     operation;
    logic [31:0]              operand_a;
    logic [31:0]              operand_b;
    logic [31:0]              imm;
    logic [TRANS_ID_BITS-1:0] trans_id;
  } fu_data_t;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  // Number of multiplier passes (one lane per cycle) an op needs.
  function automatic logic [2:0] lane_count(fu_op op);
    case (op)
      SMAQA, UMAQA, KHM8: return 3'd4;
      KHM16:              return 3'd2;
      default:            return 3'd1;
    endcase
  endfunction
endpackage

// File: rtl/simd_mul_lane.sv
// Shared 17x17 signed multiplier; 8-bit or 16-bit operands widened to 17 bits
// with per-operand sign/zero extension.
module simd_mul_lane (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        sgn_a,
  input  logic        sgn_b,
  input  logic        w16,
  output logic [33:0] prod
);
  logic [16:0] ext_a, ext_b;

  always_comb begin
    ext_a = w16 ? {sgn_a & a[15], a} : {{9{sgn_a & a[7]}}, a[7:0]};
    ext_b = w16 ? {sgn_b & b[15], b} : {{9{sgn_b & b[7]}}, b[7:0]};
  end

  assign prod = $signed({{17{ext_a[16]}}, ext_a}) * $signed({{17{ext_b[16]}}, ext_b});
endmodule

// File: rtl/simd_mul_unit.sv
// Multi-cycle packed-SIMD multiply / multiply-accumulate unit. One lane goes
// through the shared multiplier per cycle; result and ov register on the last lane.
module simd_mul_unit
  import simd_mul_unit_pkg::*;
#(
  parameter cva6_cfg_t CVA6Cfg = cva6_cfg_empty
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  fu_data_t                 fu_data_i,
  input  logic                     simd_mul_valid_i,
  output logic                     simd_mul_ready_o,
  output logic                     simd_mul_valid_o,
  output logic [31:0]              simd_mul_result_o,
  output logic [TRANS_ID_BITS-1:0] simd_mul_trans_id_o,
  output logic                     simd_mul_ov_o
);
  localparam int unsigned XLEN = CVA6Cfg.XLEN;

  state_t                   state;
  fu_op                     op_q;
  logic [XLEN-1:0]          a_q, b_q, acc_q, acc_nxt;
  logic [TRANS_ID_BITS-1:0] tid_q;
  logic [1:0]               cnt_q, last_q;
  logic                     ov_q, sat;
  logic [15:0]              lane_a, lane_b;
  logic                     sgn, w16;
  logic [33:0]              prod;
  logic                     unused_prod_hi;
  logic                     accept;

  assign accept = simd_mul_valid_i && simd_mul_ready_o && !flush_i;
  assign unused_prod_hi = ^prod[33:32];

  // Lane select: bytes by counter for 8-bit ops, halves for KHM16.
  always_comb begin
    lane_a = {8'h00, a_q[{cnt_q, 3'b000} +: 8]};
    lane_b = {8'h00, b_q[{cnt_q, 3'b000} +: 8]};
    sgn    = 1'b1;
    w16    = 1'b0;
    case (op_q)
      UMAQA: sgn = 1'b0;
      KHM16: begin
        lane_a = a_q[{cnt_q[0], 4'b0000} +: 16];
        lane_b = b_q[{cnt_q[0], 4'b0000} +: 16];
        w16    = 1'b1;
      end
      SMBB16: begin
        lane_a = a_q[15:0];
        lane_b = b_q[15:0];
        w16    = 1'b1;
      end
      default: ;
    endcase
  end

  simd_mul_lane u_lane (
    .a    (lane_a),
    .b    (lane_b),
    .sgn_a(sgn),
    .sgn_b(sgn),
    .w16  (w16),
    .prod (prod)
  );

  // Q7/Q15 saturation only hits on -1 * -1; detect it on the operands.
  always_comb begin
    acc_nxt = acc_q;
    sat     = 1'b0;
    case (op_q)
      SMAQA, UMAQA: acc_nxt = acc_q + prod[31:0];
      KHM8: begin
        sat = (lane_a[7:0] == 8'h80) && (lane_b[7:0] == 8'h80);
        acc_nxt[{cnt_q, 3'b000} +: 8] = sat ? 8'h7F : prod[14:7];
      end
      KHM16: begin
        sat = (lane_a == 16'h8000) && (lane_b == 16'h8000);
        acc_nxt[{cnt_q[0], 4'b0000} +: 16] = sat ? 16'h7FFF : prod[30:15];
      end
      SMBB16:  acc_nxt = prod[31:0];
      default: acc_nxt = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state               <= IDLE;
      op_q                <= ADD;
      a_q                 <= '0;
      b_q                 <= '0;
      acc_q               <= '0;
      tid_q               <= '0;
      cnt_q               <= '0;
      last_q              <= '0;
      ov_q                <= 1'b0;
      simd_mul_ready_o    <= 1'b1;
      simd_mul_valid_o    <= 1'b0;
      simd_mul_result_o   <= '0;
      simd_mul_trans_id_o <= '0;
      simd_mul_ov_o       <= 1'b0;
    end else begin
      simd_mul_valid_o <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            op_q             <= fu_data_i.operation;
            a_q              <= fu_data_i.operand_a;
            b_q              <= fu_data_i.operand_b;
            acc_q            <= fu_data_i.imm;
            tid_q            <= fu_data_i.trans_id;
            cnt_q            <= '0;
            last_q           <= 2'(lane_count(fu_data_i.operation) - 3'd1);
            ov_q             <= 1'b0;
            simd_mul_ready_o <= 1'b0;
            state            <= BUSY;
          end else begin
            simd_mul_ready_o <= 1'b1;
            state            <= IDLE;
          end
        end
        BUSY: begin
          if (flush_i) begin
            simd_mul_ready_o <= 1'b1;
            state            <= IDLE;
          end else begin
            acc_q <= acc_nxt;
            ov_q  <= ov_q | sat;
            cnt_q <= cnt_q + 2'd1;
            if (cnt_q == last_q) begin
              simd_mul_result_o   <= acc_nxt;
              simd_mul_ov_o       <= ov_q | sat;
              simd_mul_trans_id_o <= tid_q;
              simd_mul_valid_o    <= 1'b1;
              simd_mul_ready_o    <= 1'b1;
              state               <= DONE;
            end
          end
        end
        default: begin
          simd_mul_ready_o <= 1'b1;
          state            <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_simd_mul_unit.sv
// Randomized + directed bench for simd_mul_unit against an arithmetic reference model.
module tb_simd_mul_unit;
  import simd_mul_unit_pkg::*;

  logic                     clk_i = 1'b0;
  logic                     rst_ni = 1'b0;
  logic                     flush_i = 1'b0;
  logic                     valid_i = 1'b0;
  fu_data_t                 fu_data = '0;
  logic                     ready_o, valid_o, ov_o;
  logic [31:0]              result_o;
  logic [TRANS_ID_BITS-1:0] tid_o;
  int nvec = 0;
  int nerr = 0;

  always #5 clk_i = ~clk_i;

  simd_mul_unit dut (
    .clk_i              (clk_i),
    .rst_ni             (rst_ni),
    .flush_i            (flush_i),
    .fu_data_i          (fu_data),
    .simd_mul_valid_i   (valid_i),
    .simd_mul_ready_o   (ready_o),
    .simd_mul_valid_o   (valid_o),
    .simd_mul_result_o  (result_o),
    .simd_mul_trans_id_o(tid_o),
    .simd_mul_ov_o      (ov_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // Reference: plain signed/unsigned integer arithmetic per lane.
  function automatic void model(input fu_op op, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] imm, output logic [31:0] r,
                                output logic ov, output int n);
    int sa, sb, p;
    logic [31:0] s;
    r = '0; ov = 1'b0; n = 1;
    case (op)
      SMAQA, UMAQA: begin
        n = 4; s = imm;
        for (int i = 0; i < 4; i++) begin
          if (op == SMAQA) begin
            sa = int'($signed(a[8*i +: 8])); sb = int'($signed(b[8*i +: 8]));
          end else begin
            sa = int'({24'b0, a[8*i +: 8]}); sb = int'({24'b0, b[8*i +: 8]});
          end
          s = s + 32'(sa * sb);
        end
        r = s;
      end
      KHM8: begin
        n = 4;
        for (int i = 0; i < 4; i++) begin
          sa = int'($signed(a[8*i +: 8])); sb = int'($signed(b[8*i +: 8]));
          if (sa == -128 && sb == -128) begin r[8*i +: 8] = 8'h7F; ov = 1'b1; end
          else begin p = (sa * sb) >>> 7; r[8*i +: 8] = p[7:0]; end
        end
      end
      KHM16: begin
        n = 2;
        for (int i = 0; i < 2; i++) begin
          sa = int'($signed(a[16*i +: 16])); sb = int'($signed(b[16*i +: 16]));
          if (sa == -32768 && sb == -32768) begin r[16*i +: 16] = 16'h7FFF; ov = 1'b1; end
          else begin p = (sa * sb) >>> 15; r[16*i +: 16] = p[15:0]; end
        end
      end
      SMBB16: begin
        sa = int'($signed(a[15:0])); sb = int'($signed(b[15:0]));
        r = 32'(sa * sb);
      end
      default: ;
    endcase
  endfunction

  // Drive one request for a cycle; returns at the negedge of the first post-accept cycle.
  task automatic issue(input fu_op op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] imm, input logic [TRANS_ID_BITS-1:0] id);
    valid_i = 1'b1;
    fu_data.operation = op;
    fu_data.operand_a = a;
    fu_data.operand_b = b;
    fu_data.imm       = imm;
    fu_data.trans_id  = id;
    @(negedge clk_i);
    valid_i = 1'b0;
  endtask

  // Cycles from accept to valid_o, bounded; -1 on timeout.
  task automatic wait_done(output int lat);
    lat = 1;
    while (!valid_o && lat < 20) begin @(negedge clk_i); lat++; end
    if (!valid_o) lat = -1;
  endtask

  task automatic watch_quiet(input string tag, input int cycles);
    int seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk_i);
      if (valid_o) seen++;
    end
    chk(tag, 32'(seen), 32'd0);
  endtask

  task automatic run_chk(input string tag, input fu_op op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] imm,
                         input logic [31:0] exp_r, input logic exp_ov, input int exp_n);
    int lat;
    logic [TRANS_ID_BITS-1:0] id = TRANS_ID_BITS'($urandom);
    issue(op, a, b, imm, id);
    wait_done(lat);
    chk({tag, "_lat"}, 32'(lat), 32'(exp_n + 1));
    chk({tag, "_res"}, result_o, exp_r);
    chk({tag, "_ov"}, 32'(ov_o), 32'(exp_ov));
    chk({tag, "_tid"}, 32'(tid_o), 32'(id));
    @(negedge clk_i);
    chk({tag, "_pulse"}, 32'(valid_o), 32'd0);
  endtask

  function automatic logic [31:0] rnd_opnd(input fu_op op);
    logic [31:0] v = $urandom;
    for (int i = 0; i < 4; i++)
      if ($urandom_range(0, 3) == 0) v[8*i +: 8] = 8'h80;
    if (op == KHM16)
      for (int i = 0; i < 2; i++)
        if ($urandom_range(0, 2) == 0) v[16*i +: 16] = 16'h8000;
    return v;
  endfunction

  initial begin
    int lat;
    fu_op op;
    logic [31:0] a, b, imm, er;
    logic eov;
    int en;

    @(negedge clk_i);
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_ready", 32'(ready_o), 32'd1);
    chk("rst_res", result_o, 32'd0);
    chk("rst_tid", 32'(tid_o), 32'd0);
    chk("rst_ov", 32'(ov_o), 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);

    run_chk("smaqa", SMAQA, 32'h01FF7F80, 32'h02020202, 32'h10, 32'h0000000E, 1'b0, 4);
    run_chk("umaqa", UMAQA, 32'h01FF7F80, 32'h02020202, 32'h10, 32'h0000040E, 1'b0, 4);
    run_chk("khm8", KHM8, 32'h80804040, 32'h807F4040, 32'h0, 32'h7F812020, 1'b1, 4);
    run_chk("khm16", KHM16, 32'h80004000, 32'h80004000, 32'h0, 32'h7FFF2000, 1'b1, 2);
    run_chk("unrec", ADD, 32'h12345678, 32'h9ABCDEF0, 32'h55, 32'h0, 1'b0, 1);

    // SMBB16 then a second one issued in the DONE cycle
    issue(SMBB16, 32'h1234FFFF, 32'hABCD0003, 32'h0, 3'd5);
    wait_done(lat);
    chk("smbb_lat", 32'(lat), 32'd2);
    chk("smbb_res", result_o, 32'hFFFFFFFD);
    chk("smbb_done_ready", 32'(ready_o), 32'd1);
    issue(SMBB16, 32'h00000100, 32'h0000FF00, 32'h0, 3'd6);
    wait_done(lat);
    chk("b2b_lat", 32'(lat), 32'd2);
    chk("b2b_res", result_o, 32'hFFFF0000);
    chk("b2b_tid", 32'(tid_o), 32'd6);
    @(negedge clk_i);

    // Flush in BUSY cycle 2
    issue(SMAQA, 32'h01010101, 32'h01010101, 32'h0, 3'd1);
    @(negedge clk_i);
    flush_i = 1'b1;
    @(negedge clk_i);
    flush_i = 1'b0;
    chk("flush_busy_ready", 32'(ready_o), 32'd1);
    chk("flush_busy_valid", 32'(valid_o), 32'd0);
    watch_quiet("flush_busy_quiet", 8);

    // Flush with request in IDLE: not accepted
    valid_i = 1'b1; flush_i = 1'b1;
    @(negedge clk_i);
    valid_i = 1'b0; flush_i = 1'b0;
    chk("flush_idle_ready", 32'(ready_o), 32'd1);
    watch_quiet("flush_idle_quiet", 6);

    // Flush in DONE: completed op still reported, concurrent request dropped
    issue(SMBB16, 32'h00000002, 32'h00000003, 32'h0, 3'd2);
    wait_done(lat);
    chk("flush_done_valid", 32'(valid_o), 32'd1);
    chk("flush_done_res", result_o, 32'd6);
    flush_i = 1'b1;
    issue(SMBB16, 32'h7, 32'h7, 32'h0, 3'd3);
    flush_i = 1'b0;
    chk("flush_done_ready", 32'(ready_o), 32'd1);
    watch_quiet("flush_done_quiet", 6);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 5))
        0: op = SMAQA;
        1: op = UMAQA;
        2: op = KHM8;
        3: op = KHM16;
        4: op = SMBB16;
        default: op = ADD;
      endcase
      a = rnd_opnd(op); b = rnd_opnd(op); imm = $urandom;
      model(op, a, b, imm, er, eov, en);
      run_chk("rnd", op, a, b, imm, er, eov, en);
    end

    // Reset mid-op after a nonzero result
    run_chk("pre_rst", KHM8, 32'h80804040, 32'h807F4040, 32'h0, 32'h7F812020, 1'b1, 4);
    issue(SMAQA, 32'h01010101, 32'h01010101, 32'h0, 3'd7);
    rst_ni = 1'b0;
    #1;
    chk("midrst_valid", 32'(valid_o), 32'd0);
    chk("midrst_ready", 32'(ready_o), 32'd1);
    chk("midrst_res", result_o, 32'd0);
    chk("midrst_tid", 32'(tid_o), 32'd0);
    chk("midrst_ov", 32'(ov_o), 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    watch_quiet("midrst_quiet", 8);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/simd_mul_unit.md
Name: simd_mul_unit

Overview:
- Multi-cycle packed-SIMD multiply/multiply-accumulate functional unit for the cv32a6 execute stage.
- Sits beside the packed-SIMD ALU: fed by the same issue path with fu_data_t, and returns a result with its trans_id to writeback.
- Uses one shared 17x17 signed multiplier, iterated one lane per cycle, so area stays small while covering the P-extension multiply ops.

Parameters:
- CVA6Cfg, config_pkg::cva6_cfg_empty, core configuration; XLEN fixed at 32.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- flush_i  in  1  synchronous pipeline flush; aborts the in-flight op.
- fu_data_i  in  fu_data_t  operation, operand_a, operand_b, imm (accumulator rd value), trans_id.
- simd_mul_valid_i  in  1  issue request.
- simd_mul_ready_o  out  1  unit can accept a request.
- simd_mul_valid_o  out  1  result valid, single-cycle pulse.
- simd_mul_result_o  out  32  result.
- simd_mul_trans_id_o  out  TRANS_ID_BITS  trans_id of the result.
- simd_mul_ov_o  out  1  saturation occurred; qualified by valid_o and feeds the vxsat/OV CSR bit.

Behaviour:
- Reset values: valid_o=0, ready_o=1, result_o=0, trans_id_o=0, ov_o=0; FSM in IDLE; accumulator and lane counter cleared.
- FSM states are IDLE, BUSY and DONE.
  - ready_o=1 in IDLE and in DONE; ready_o=0 in BUSY.
  - Accept condition: valid_i && ready_o && !flush_i. On accept, capture operation, operands, imm and trans_id; clear the lane counter; go to BUSY.
  - BUSY: process one lane per cycle. After N cycles, register the result and ov, then go to DONE.
  - N is 4 for SMAQA, UMAQA and KHM8; 2 for KHM16; 1 for SMBB16.
  - DONE: valid_o=1 for exactly one cycle. Next state is BUSY if a new request is accepted in that cycle, otherwise IDLE. This gives back-to-back issue with no bubble.
- Latency: a request accepted in cycle c produces valid_o in cycle c+N+1.
- Result and trans_id are held after DONE until the next completion.
- SMAQA: result = imm + sum of the four signed 8x8 lane products, modulo 2^32, no saturation, ov=0.
- UMAQA: same as SMAQA with unsigned lanes.
- KHM8, per 8-bit lane: (a*b)>>>7 in signed Q7.
  - Lane a=b=0x80 saturates to 0x7F and sets ov.
  - Unsaturated lanes keep bits [14:7] of the product.
- KHM16, per 16-bit lane: (a*b)>>>15. Lane a=b=0x8000 saturates to 0x7FFF and sets ov.
- SMBB16: signed a[15:0]*b[15:0], full 32-bit result, ov=0.
- ov_o is the OR of all lane saturations of that op.
- Unrecognised operation: accepted, N=1, result 0, ov 0.
- flush_i has priority over everything.
  - In BUSY: go to IDLE; no valid_o for the aborted op.
  - In DONE: valid_o is still driven that cycle, because the op has already completed; any request in that same cycle is dropped.
  - flush_i and valid_i together in IDLE: the request is not accepted.
- Reset mid-op: the state returns to reset values immediately and no valid_o is produced.

Decomposition:
- Additions to ariane_pkg:
  - fu_op enumerators SMAQA, UMAQA, KHM8, KHM16, SMBB16.
  - FU type SIMD_MUL.
  - A lane-count function that maps fu_op to N.
- Sub-module simd_mul_lane: combinational 17x17 signed multiplier.
  - Inputs: two 16-bit operands, a per-operand signed/unsigned select, and an 8/16 lane-width select.
  - Output: the 34-bit product.
  - Instantiated once and driven by the lane mux in simd_mul_unit.

Test Plan:
- SMAQA: a=0x01FF7F80, b=0x02020202, imm=0x10 -> result 0x0000000E, ov=0, valid exactly 5 cycles after accept, trans_id echoed.
- UMAQA with the same operands -> result 0x0000040E, ov=0.
- KHM8: a=0x80804040, b=0x807F4040 -> result 0x7F812020, ov=1.
- KHM16: a=0x80004000, b=0x80004000 -> result 0x7FFF2000, ov=1, valid at c+3.
- SMBB16: a=0x1234FFFF, b=0xABCD0003 -> result 0xFFFFFFFD at c+2. A second SMBB16 issued in the DONE cycle completes 2 cycles later with no bubble.
- SMAQA aborted by flush_i in BUSY cycle 2 -> no valid_o and ready_o=1 next cycle. Separately, assert rst_ni low mid-op -> all outputs return to reset values asynchronously.
